// File: rtl/trigger_arbiter.sv
// Arbitrates NREQ edge-triggered sources onto one fixed-width trigger pulse with holdoff.
// Define TRIG_ARB_ROUND_ROBIN_EN for round-robin priority; default is fixed lowest-index.

module trigger_arbiter_src (
  input  logic CLK,
  input  logic RESET,
  input  logic req,
  input  logic en,
  input  logic grant,
  output logic cand,
  output logic lost
);
  logic req_q, pend, edge_det;

  assign edge_det = req & ~req_q & en;
  assign cand     = pend | edge_det;
  // A fresh edge on an already-pending source is lost unless this grant re-arms it.
  assign lost     = edge_det & pend & ~grant;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      req_q <= 1'b1;
      pend  <= 1'b0;
    end else begin
      req_q <= req;
      if (!en)        pend <= 1'b0;
      else if (grant) pend <= pend & edge_det;
      else            pend <= pend | edge_det;
    end
  end
endmodule

module trigger_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int SLEN = 5,
  parameter int DEAD = 8,
  parameter int CW   = 16
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [NREQ-1:0] REQ,
  input  logic [NREQ-1:0] ENABLE,
  input  logic            CLR_CNT,
  output logic            OUT,
  output logic [IDW-1:0]  OUT_ID,
  output logic            BUSY,
  output logic [CW-1:0]   LOST_CNT
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

  localparam int CMAX = (SLEN > DEAD) ? SLEN : ((DEAD > 1) ? DEAD : 1);
  localparam int CNTW = $clog2(CMAX + 1);
  localparam int LW   = $clog2(NREQ + 1);
  localparam logic [CW-1:0] LMAX = '1;

  logic [1:0]       state;
  logic [CNTW-1:0]  cnt;
  logic [NREQ-1:0]  cand, lost, grant;
  logic [IDW-1:0]   win;
  logic             take;
  logic [LW-1:0]    n_lost;
  logic [CW+LW-1:0] lsum;

  genvar g;
  generate
    for (g = 0; g < NREQ; g++) begin : g_src
      trigger_arbiter_src u_src (
        .CLK   (CLK),
        .RESET (RESET),
        .req   (REQ[g]),
        .en    (ENABLE[g]),
        .grant (grant[g]),
        .cand  (cand[g]),
        .lost  (lost[g])
      );
    end
  endgenerate

`ifdef TRIG_ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] ptr;
  logic           found;
  int             idx;

  // Search starts at ptr and wraps, so the source after the last grant wins ties.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET)     ptr <= '0;
    else if (take) ptr <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
  end
`else
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (cand[i]) win = IDW'(i);
  end
`endif

  assign take = (state == S_IDLE) && (|cand);
  assign BUSY = (state != S_IDLE);

  always_comb begin
    grant = '0;
    if (take) grant[win] = 1'b1;
  end

  always_comb begin
    n_lost = '0;
    for (int i = 0; i < NREQ; i++) n_lost = n_lost + LW'(lost[i]);
    lsum = (CW+LW)'(LOST_CNT) + (CW+LW)'(n_lost);
  end

  always_ff @(posedge CLK) begin
    if (RESET || CLR_CNT)             LOST_CNT <= '0;
    else if (lsum > (CW+LW)'(LMAX))   LOST_CNT <= LMAX;
    else                              LOST_CNT <= lsum[CW-1:0];
  end

  // cnt holds remaining cycles minus one in ACTIVE and HOLD.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= S_IDLE;
      OUT    <= 1'b0;
      OUT_ID <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: if (take) begin
          state  <= S_ACTIVE;
          OUT    <= 1'b1;
          OUT_ID <= win;
          cnt    <= CNTW'(SLEN - 1);
        end
        S_ACTIVE: if (cnt == '0) begin
          OUT <= 1'b0;
          if (DEAD == 0) state <= S_IDLE;
          else begin
            state <= S_HOLD;
            cnt   <= CNTW'((DEAD > 0) ? DEAD - 1 : 0);
          end
        end else cnt <= cnt - 1'b1;
        S_HOLD: if (cnt == '0) state <= S_IDLE;
                else           cnt   <= cnt - 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trigger_arbiter.sv
// Random + directed bench: two arbiter configs (DEAD=8/CW=16, DEAD=0/CW=2) against a cycle model.

module tb_trigger_arbiter;
  localparam int NREQ = 4;
  localparam int SLEN = 5;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] REQ, ENABLE;
  logic       CLR_CNT;

  logic       out0, busy0, out1, busy1;
  logic [1:0] id0, id1;
  logic [15:0] lc0;
  logic [1:0]  lc1;

  int n_tests = 0;
  int n_fail  = 0;

  int m_dead[2] = '{8, 0};
  int m_cap[2]  = '{65535, 3};
  logic [3:0] m_reqq[2];
  logic [3:0] m_pend[2];
  int m_out[2], m_busy[2], m_id[2], m_lost[2];
`ifdef TRIG_ARB_ROUND_ROBIN_EN
  int m_ptr[2];
`endif

  always #5 CLK = ~CLK;

  trigger_arbiter #(.NREQ(4), .IDW(2), .SLEN(5), .DEAD(8), .CW(16)) dut0 (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .ENABLE(ENABLE), .CLR_CNT(CLR_CNT),
    .OUT(out0), .OUT_ID(id0), .BUSY(busy0), .LOST_CNT(lc0));

  trigger_arbiter #(.NREQ(4), .IDW(2), .SLEN(5), .DEAD(0), .CW(2)) dut1 (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .ENABLE(ENABLE), .CLR_CNT(CLR_CNT),
    .OUT(out1), .OUT_ID(id1), .BUSY(busy1), .LOST_CNT(lc1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Model: pulse/busy tracked as remaining-cycle budgets, pend as plain bit sets.
  task automatic model_step(input int c);
    logic [3:0] e, np;
    int gnt, losses, tot;
    if (RESET) begin
      m_reqq[c] = 4'hF; m_pend[c] = 4'h0;
      m_out[c] = 0; m_busy[c] = 0; m_id[c] = 0; m_lost[c] = 0;
`ifdef TRIG_ARB_ROUND_ROBIN_EN
      m_ptr[c] = 0;
`endif
      return;
    end
    e = REQ & ~m_reqq[c] & ENABLE;
    gnt = -1;
    if (m_busy[c] == 0)
      for (int k = 0; k < NREQ; k++) begin
        int idx;
`ifdef TRIG_ARB_ROUND_ROBIN_EN
        idx = (m_ptr[c] + k) % NREQ;
`else
        idx = k;
`endif
        if (gnt < 0 && (m_pend[c][idx] || e[idx])) gnt = idx;
      end
    losses = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (e[i] && m_pend[c][i] && i != gnt) losses++;
      if (!ENABLE[i])   np[i] = 1'b0;
      else if (i == gnt) np[i] = m_pend[c][i] && e[i];
      else              np[i] = m_pend[c][i] || e[i];
    end
    m_pend[c] = np;
    tot = m_lost[c] + losses;
    m_lost[c] = CLR_CNT ? 0 : ((tot > m_cap[c]) ? m_cap[c] : tot);
    if (m_busy[c] > 0) begin
      m_busy[c]--;
      if (m_out[c] > 0) m_out[c]--;
    end else if (gnt >= 0) begin
      m_out[c]  = SLEN;
      m_busy[c] = SLEN + m_dead[c];
      m_id[c]   = gnt;
`ifdef TRIG_ARB_ROUND_ROBIN_EN
      m_ptr[c]  = (gnt + 1) % NREQ;
`endif
    end
    m_reqq[c] = REQ;
  endtask

  task automatic step();
    @(posedge CLK);
    model_step(0);
    model_step(1);
    #1;
    chk("out0",  32'(out0),  32'(m_out[0] > 0));
    chk("busy0", 32'(busy0), 32'(m_busy[0] > 0));
    chk("id0",   32'(id0),   32'(m_id[0]));
    chk("lost0", 32'(lc0),   32'(m_lost[0]));
    chk("out1",  32'(out1),  32'(m_out[1] > 0));
    chk("busy1", 32'(busy1), 32'(m_busy[1] > 0));
    chk("id1",   32'(id1),   32'(m_id[1]));
    chk("lost1", 32'(lc1),   32'(m_lost[1]));
  endtask

  initial begin
    int oh, bh, rises, lows, gap;
    logic prev;
    int ids[$];

    RESET = 1'b1; REQ = 4'h0; ENABLE = 4'hF; CLR_CNT = 1'b0;
    step(); step();
    chk("rst_out", 32'(out0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_id", 32'(id0), 0);
    chk("rst_lost", 32'(lc0), 0);
    RESET = 1'b0;
    repeat (3) step();

    // single request on source 2
    REQ = 4'b0100;
    oh = 0; bh = 0;
    step();
    chk("lat_out", 32'(out0), 1);
    oh += out0; bh += busy0;
    repeat (19) begin step(); oh += out0; bh += busy0; end
    chk("pulse_len", 32'(oh), 5);
    chk("busy_len", 32'(bh), 13);
    chk("pulse_id", 32'(id0), 2);
    chk("pulse_lost", 32'(lc0), 0);
    REQ = 4'b0000;
    repeat (3) step();

    // simultaneous requests on 1 and 3
    REQ = 4'b1010;
    prev = 1'b0; lows = 0; gap = -1;
    repeat (40) begin
      step();
      if (out0) begin
        if (!prev) begin
          ids.push_back(id0);
          if (ids.size() == 2) gap = lows;
        end
        lows = 0;
      end else lows++;
      prev = out0;
    end
    chk("sim_cnt", 32'(ids.size()), 2);
    if (ids.size() == 2) begin
`ifdef TRIG_ARB_ROUND_ROBIN_EN
      chk("sim_first", 32'(ids[0]), 3);
      chk("sim_second", 32'(ids[1]), 1);
`else
      chk("sim_first", 32'(ids[0]), 1);
      chk("sim_second", 32'(ids[1]), 3);
`endif
    end
    chk("sim_gap", 32'(gap), 9);
    REQ = 4'b0000;
    repeat (3) step();

    // three edges on source 0 inside one busy window
    CLR_CNT = 1'b1; step(); CLR_CNT = 1'b0;
    rises = 0; prev = out0;
    for (int k = 0; k < 6; k++) begin
      REQ = (k % 2 == 0) ? 4'b0001 : 4'b0000;
      step();
      if (out0 && !prev) rises++;
      prev = out0;
    end
    repeat (30) begin
      step();
      if (out0 && !prev) rises++;
      prev = out0;
    end
    chk("loss_cnt0", 32'(lc0), 1);
    chk("loss_cnt1", 32'(lc1), 1);
    chk("loss_pulses", 32'(rises), 2);

    // masked source produces nothing
    ENABLE = 4'b1011; REQ = 4'b0100; oh = 0;
    repeat (20) begin step(); oh += out0; end
    chk("mask_pulse", 32'(oh), 0);
    chk("mask_lost", 32'(lc0), 1);
    ENABLE = 4'hF; REQ = 4'b0000;
    repeat (3) step();

    // reset mid-pulse with a pending source, lines held high through reset
    REQ = 4'b0001; step(); REQ = 4'b0011; step(); step();
    RESET = 1'b1; REQ = 4'b1011; step();
    chk("rst_mid_out", 32'(out0), 0);
    RESET = 1'b0; oh = 0;
    repeat (20) begin step(); oh += out0; end
    chk("rst_no_pulse", 32'(oh), 0);

    // random traffic
    for (int t = 0; t < 2000; t++) begin
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(3) == 0) REQ[i] = ~REQ[i];
      ENABLE  = ($urandom_range(19) == 0) ? 4'($urandom) : 4'hF;
      CLR_CNT = ($urandom_range(39) == 0);
      RESET   = ($urandom_range(299) == 0);
      step();
    end
    RESET = 1'b0; CLR_CNT = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
